// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the imem ready/ack port and feeds IF/ID.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_4,
    output logic        if_valid,
    output logic        if_clear,
    output logic [31:0] pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc4_q, buf_pc4_d;

    logic [31:0] redirect_tgt;
    logic [31:0] pc_plus4;
    logic        unused_rpc_lo;

    assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
    assign pc_plus4      = pc_q + 32'd4;
    assign unused_rpc_lo = ^redirect_pc[1:0];
    assign pc            = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            addr_q     <= 32'd0;
            buf_inst_q <= 32'd0;
            buf_pc4_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        buf_inst_d  = buf_inst_q;
        buf_pc4_d   = buf_pc4_q;
        imem_req    = 1'b0;
        imem_addr   = 32'd0;
        instruction = 32'd0;
        pc_4        = 32'd0;
        if_valid    = 1'b0;
        if_clear    = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                addr_d    = pc_q;
                if_clear  = redirect;
                if (imem_ack) begin
                    instruction = imem_rdata;
                    pc_4        = pc_plus4;
                end
                // Redirect wins over stall; an unacked request must be drained first.
                if (redirect) begin
                    pc_d = redirect_tgt;
                    if (!imem_ack) state_d = StDrain;
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (stall) begin
                        buf_inst_d = imem_rdata;
                        buf_pc4_d  = pc_plus4;
                        state_d    = StHold;
                    end else begin
                        if_valid = 1'b1;
                    end
                end
            end
            StHold: begin
                instruction = buf_inst_q;
                pc_4        = buf_pc4_q;
                if_clear    = redirect;
                if (redirect) begin
                    pc_d    = redirect_tgt;
                    state_d = StFetch;
                end else if (!stall) begin
                    if_valid = 1'b1;
                    state_d  = StFetch;
                end
            end
            StDrain: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if_clear  = redirect;
                if (redirect) pc_d = redirect_tgt;
                if (imem_ack) state_d = StFetch;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (if_valid) fetch_cnt <= fetch_cnt + 32'd1;
            if (if_clear) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, issues requests on a ready/ack instruction-memory port, and feeds the IF/ID pipeline register with `instruction`, `pc_4`, a write strobe and a flush strobe. It absorbs load-use stalls from ID with a one-entry holding buffer, and branch/jump redirects from later stages with a drain state, so the memory handshake is never violated.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- `clk`  in  1  pipeline clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  hazard unit: hold fetch output, do not advance IF/ID
- `redirect`  in  1  taken branch/jump: change PC, flush IF/ID
- `redirect_pc`  in  32  target; bits [1:0] forced to 0 internally
- `imem_req`  out  1  fetch request; held with `imem_addr` stable until `imem_ack`
- `imem_addr`  out  32  word address (byte address, [1:0]=0)
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle (may be same cycle as req)
- `imem_rdata`  in  32  fetched instruction
- `instruction`  out  32  instruction for IF/ID
- `pc_4`  out  32  address of that instruction + 4
- `if_valid`  out  1  IF/ID write enable (IRWrite)
- `if_clear`  out  1  IF/ID flush
- `pc`  out  32  current fetch PC

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. Registers: `pc`, `addr_q` (outstanding address), `buf_inst`, `buf_pc4`, state.
- IDLE: entered on reset; `imem_req`=0; next edge -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, `addr_q`<=`pc`.
  - ack, !stall, !redirect: `instruction`=`imem_rdata`, `pc_4`=`pc`+4, `if_valid`=1; `pc`<=`pc`+4; stay.
  - ack, stall, !redirect: `buf_inst`<=`imem_rdata`, `buf_pc4`<=`pc`+4, `pc`<=`pc`+4; -> HOLD.
  - !ack, redirect: `pc`<=`redirect_pc`; -> DRAIN.
  - ack, redirect: data dropped; `pc`<=`redirect_pc`; stay FETCH.
  - !ack, !redirect: hold; stall irrelevant.
- HOLD: `imem_req`=0; `instruction`=`buf_inst`, `pc_4`=`buf_pc4`; `if_valid`=!stall; !stall -> FETCH; redirect -> FETCH with `pc`<=`redirect_pc`, buffer discarded, `if_valid`=0.
- DRAIN: `imem_req`=1, `imem_addr`=`addr_q`; on ack data discarded -> FETCH. Further redirect updates `pc`, stays DRAIN until ack.
- `if_clear`=`redirect` (combinational) in every state except IDLE; `if_valid` forced 0 whenever `if_clear`=1.
- Redirect beats stall when both asserted.
- `instruction`/`pc_4` read 0 when no source is valid (IDLE, FETCH without ack, DRAIN).
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset: `pc`=`RESET_PC`, state IDLE, `imem_req`=0, `imem_addr`=0, `instruction`=0, `pc_4`=0, `if_valid`=0, `if_clear`=0.
- First request one cycle after `rst_n` deasserts; zero-wait memory yields one instruction per cycle.
- Fetch output is combinational from `imem_rdata` in the ack cycle; IF/ID captures it on the same edge.
- Redirect with no outstanding request: `imem_addr`=`redirect_pc` on the next cycle. With an outstanding request: after the drain ack, plus one cycle.
- HOLD release: buffered instruction written the cycle `stall` drops; new request the cycle after.
- Reset mid-transaction: immediate return to IDLE; the outstanding ack is ignored.

## Configuration
- `IF_PERF_CNT_EN`: when defined, adds outputs `fetch_cnt` (32, counts cycles with `if_valid`=1) and `flush_cnt` (32, counts cycles with `if_clear`=1). Both reset to 0, wrap at 2^32. When undefined, the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset release, ack tied 1, rdata=addr: `imem_addr` 0,4,8,... from cycle 1; `if_valid`=1 each cycle, `pc_4`=addr+4.
- Stall high 3 cycles during ack at addr 8: HOLD shows `instruction`=data@8, `if_valid`=0 for 3 cycles, then 1 with `pc_4`=12; next request at 12.
- Memory with 3-cycle ack latency, redirect to 0x100 in the 1st wait cycle: `imem_addr` stays at old address until ack, data not written, `if_clear`=1 one cycle, next request 0x100.
- Redirect and stall together in HOLD, `redirect_pc`=0x203: buffer dropped, `if_valid`=0, next `imem_addr`=0x200.
- `RESET_PC`=32'hFFFF_FFFC: second fetch address 0; `rst_n` pulsed low mid-wait -> all outputs return to reset values immediately.
- With `IF_PERF_CNT_EN`: 10 fetches, 2 redirects -> `fetch_cnt`=10, `flush_cnt`=2.
